// File: rtl/exe_muldiv_unit.sv
// HI/LO multiply/divide unit for the EXE stage: single-cycle MULT/MULTU and
// 32-cycle restoring DIV/DIVU, with MTHI/MTLO writes and pipeline stall.
module exe_muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;

  logic        op_signed;
  logic        last_step;
  logic [31:0] a_abs_in;
  logic [31:0] b_abs;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  assign stall     = (start && (state == IDLE)) || busy;
  assign op_signed = ~op_q[0];
  assign last_step = (cnt == 6'd31);

  // Dividend magnitude is captured at accept; it is shifted out of quo MSB-first.
  assign a_abs_in = (!op[0] && a[31]) ? -a : a;
  assign b_abs    = (op_signed && b_q[31]) ? -b_q : b_q;

  assign mul_a   = {{32{op_signed & a_q[31]}}, a_q};
  assign mul_b   = {{32{op_signed & b_q[31]}}, b_q};
  assign product = mul_a * mul_b;

  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, b_abs};
  assign qbit    = ~diff[32];
  assign rem_nx  = qbit ? diff[31:0] : shifted[31:0];
  assign quo_nx  = {quo[30:0], qbit};

  // Divide by zero forces an all-ones quotient regardless of sign fixup.
  assign div_lo = (b_q == 32'd0) ? 32'hFFFF_FFFF :
                  ((op_signed && (a_q[31] ^ b_q[31])) ? -quo_nx : quo_nx);
  assign div_hi = (op_signed && a_q[31]) ? -rem_nx : rem_nx;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = op[1] ? DIV : MUL;
      MUL:  state_n = FIN;
      DIV:  if (last_step) state_n = FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == MUL) || (state_n == DIV);
      done  <= (state_n == FIN);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      cnt  <= 6'd0;
      rem  <= 32'd0;
      quo  <= 32'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            cnt  <= 6'd0;
            rem  <= 32'd0;
            quo  <= a_abs_in;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MUL: begin
          hi <= product[63:32];
          lo <= product[31:0];
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= last_step ? 6'd0 : cnt + 6'd1;
          if (last_step) begin
            hi <= div_hi;
            lo <= div_lo;
          end
        end
        FIN: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed self-checking bench for exe_muldiv_unit: multiply, divide, MTHI/MTLO
// and reset-abort scenarios with hand-computed results.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  exe_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    tick(); tick();
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);

    // Reset wins over start and MTHI in the same cycle
    apply_stimulus(2'b00, 32'd1, 32'd1);
    hi_we = 1'b1; wdata = 32'h0000_0005;
    tick();
    check_output("rst_prio_busy", {31'd0, busy}, 32'd0);
    check_output("rst_prio_hi", hi, 32'd0);
    rst_n = 1'b1; start = 1'b0; hi_we = 1'b0;
    tick();

    // MULT -2 * 3
    apply_stimulus(2'b00, 32'hFFFF_FFFE, 32'd3);
    #1;
    check_output("mult_stall", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    check_output("mult_busy", {31'd0, busy}, 32'd1);
    check_output("mult_done_early", {31'd0, done}, 32'd0);
    tick();
    check_output("mult_busy_fin", {31'd0, busy}, 32'd0);
    check_output("mult_done", {31'd0, done}, 32'd1);
    check_output("mult_hi", hi, 32'hFFFF_FFFF);
    check_output("mult_lo", lo, 32'hFFFF_FFFA);
    tick();
    check_output("mult_done_clr", {31'd0, done}, 32'd0);

    // MULTU 0xFFFFFFFF^2, two-edge latency
    apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    start = 1'b0;
    check_output("multu_lo_pending", lo, 32'hFFFF_FFFA);
    tick();
    check_output("multu_hi", hi, 32'hFFFF_FFFE);
    check_output("multu_lo", lo, 32'h0000_0001);
    tick();

    // DIV -7 / 2 with a stray start and MTLO mid-operation
    apply_stimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
    tick();
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cnt++;
      if (i == 10) begin
        apply_stimulus(2'b01, 32'd1, 32'd1);
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (i == 11) begin
        start = 1'b0; lo_we = 1'b0;
      end
      if (i == 20) check_output("div_lo_hidden", lo, 32'h0000_0001);
      tick();
    end
    check_output("div_busy_cycles", busy_cnt, 32'd32);
    check_output("div_done", {31'd0, done}, 32'd1);
    check_output("div_lo", lo, 32'hFFFF_FFFD);
    check_output("div_hi", hi, 32'hFFFF_FFFF);
    tick();
    check_output("div_done_clr", {31'd0, done}, 32'd0);

    // DIVU 100 / 0, result after exactly 33 edges
    apply_stimulus(2'b11, 32'd100, 32'd0);
    tick();
    start = 1'b0;
    repeat (31) tick();
    check_output("divz_lo_pending", lo, 32'hFFFF_FFFD);
    check_output("divz_done_pending", {31'd0, done}, 32'd0);
    tick();
    check_output("divz_lo", lo, 32'hFFFF_FFFF);
    check_output("divz_hi", hi, 32'd100);
    check_output("divz_done", {31'd0, done}, 32'd1);
    tick();

    // DIV 0x80000000 / -1 overflow case
    apply_stimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    start = 1'b0;
    repeat (32) tick();
    check_output("divovf_lo", lo, 32'h8000_0000);
    check_output("divovf_hi", hi, 32'h0000_0000);
    tick();

    // MTHI in IDLE
    hi_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    hi_we = 1'b0;
    check_output("mthi_hi", hi, 32'h1234_5678);
    check_output("mthi_lo", lo, 32'h8000_0000);

    // DIVU 9 / 2, then MTLO during FIN overrides the quotient
    apply_stimulus(2'b11, 32'd9, 32'd2);
    tick();
    start = 1'b0;
    repeat (32) tick();
    check_output("divu_lo", lo, 32'd4);
    check_output("divu_hi", hi, 32'd1);
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    lo_we = 1'b0;
    check_output("mtlo_fin_lo", lo, 32'hCAFE_F00D);
    check_output("mtlo_fin_hi", hi, 32'd1);

    // start with MTHI in IDLE: start accepted, write dropped
    apply_stimulus(2'b01, 32'd6, 32'd7);
    hi_we = 1'b1; wdata = 32'h0000_AAAA;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check_output("drop_mthi_hi", hi, 32'd1);
    tick();
    check_output("drop_mthi_lo", lo, 32'd42);
    check_output("drop_mthi_hi2", hi, 32'd0);
    tick();

    // Reset aborts DIVU 50 / 7 mid-operation
    apply_stimulus(2'b11, 32'd50, 32'd7);
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_output("abort_hi", hi, 32'd0);
    check_output("abort_lo", lo, 32'd0);
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort_done", {31'd0, done}, 32'd0);
    check_output("abort_stall_idle", {31'd0, stall}, 32'd0);
    tick();
    check_output("abort_done_after", {31'd0, done}, 32'd0);
    apply_stimulus(2'b01, 32'd6, 32'd7);
    #1;
    check_output("abort_stall_start", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    check_output("post_mul_busy", {31'd0, busy}, 32'd1);
    tick();
    check_output("post_mul_lo", lo, 32'd42);
    check_output("post_mul_hi", hi, 32'd0);
    check_output("post_mul_done", {31'd0, done}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
